// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : sprite_compositor
// Purpose  : NUM_LAYERS sprite hit-test, ROM addressing and priority/colour-key
//            composite over a background pixel. Optional macro: SPRITE_MIRROR_EN
// Revision : 1.0 - initial release
// ============================================================================
module sprite_compositor #(
    parameter int                     NUM_LAYERS = 4,
    parameter int                     COLOR_W    = 4,
    parameter int                     XY_W       = 10,
    parameter int                     SPR_W      = 16,
    parameter int                     SPR_H      = 16,
    parameter int                     ADDR_W     = 8,
    parameter int                     ROM_LAT    = 1,
    parameter logic [3*COLOR_W-1:0]   KEY_RGB    = 12'hF0F,
    localparam int                    LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int                    PIX_W      = 3 * COLOR_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pix_valid,
    input  logic [XY_W-1:0]               xpos,
    input  logic [XY_W-1:0]               ypos,
    input  logic [PIX_W-1:0]              bg_rgb,
    input  logic                          frame_start,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [LAYER_W-1:0]            cfg_layer,
    input  logic [XY_W-1:0]               cfg_x,
    input  logic [XY_W-1:0]               cfg_y,
    input  logic                          cfg_en,
`ifdef SPRITE_MIRROR_EN
    input  logic                          cfg_mirror,
`endif
    output logic [NUM_LAYERS*ADDR_W-1:0]  spr_addr,
    input  logic [NUM_LAYERS*PIX_W-1:0]   spr_rgb,
    output logic [COLOR_W-1:0]            R,
    output logic [COLOR_W-1:0]            G,
    output logic [COLOR_W-1:0]            B,
    output logic                          out_valid
);

    logic [XY_W-1:0]        r_sh_x   [NUM_LAYERS];
    logic [XY_W-1:0]        r_sh_y   [NUM_LAYERS];
    logic [XY_W-1:0]        r_act_x  [NUM_LAYERS];
    logic [XY_W-1:0]        r_act_y  [NUM_LAYERS];
    logic [NUM_LAYERS-1:0]  r_sh_en;
    logic [NUM_LAYERS-1:0]  r_act_en;
`ifdef SPRITE_MIRROR_EN
    logic [NUM_LAYERS-1:0]  r_sh_mir;
    logic [NUM_LAYERS-1:0]  r_act_mir;
`endif
    logic                   r_cfg_ready;
    logic                   w_wr;

    assign cfg_ready = r_cfg_ready;
    assign w_wr      = cfg_valid && r_cfg_ready;

    // A write landing on the frame_start cycle bypasses the shadow into the commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_ready <= 1'b1;
            r_sh_en     <= '0;
            r_act_en    <= '0;
`ifdef SPRITE_MIRROR_EN
            r_sh_mir    <= '0;
            r_act_mir   <= '0;
`endif
            for (int i = 0; i < NUM_LAYERS; i++) begin
                r_sh_x[i]  <= '0;
                r_sh_y[i]  <= '0;
                r_act_x[i] <= '0;
                r_act_y[i] <= '0;
            end
        end else begin
            r_cfg_ready <= !frame_start;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (w_wr && (cfg_layer == LAYER_W'(i))) begin
                    r_sh_x[i]  <= cfg_x;
                    r_sh_y[i]  <= cfg_y;
                    r_sh_en[i] <= cfg_en;
`ifdef SPRITE_MIRROR_EN
                    r_sh_mir[i] <= cfg_mirror;
`endif
                end
                if (frame_start) begin
                    if (w_wr && (cfg_layer == LAYER_W'(i))) begin
                        r_act_x[i]  <= cfg_x;
                        r_act_y[i]  <= cfg_y;
                        r_act_en[i] <= cfg_en;
`ifdef SPRITE_MIRROR_EN
                        r_act_mir[i] <= cfg_mirror;
`endif
                    end else begin
                        r_act_x[i]  <= r_sh_x[i];
                        r_act_y[i]  <= r_sh_y[i];
                        r_act_en[i] <= r_sh_en[i];
`ifdef SPRITE_MIRROR_EN
                        r_act_mir[i] <= r_sh_mir[i];
`endif
                    end
                end
            end
        end
    end

    logic [NUM_LAYERS-1:0]  w_hit;
    logic [ADDR_W-1:0]      w_addr [NUM_LAYERS];

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
        logic [XY_W:0]   w_x_end;
        logic [XY_W:0]   w_y_end;
        logic [XY_W-1:0] w_dx;
        logic [XY_W-1:0] w_dy;
        logic [XY_W-1:0] w_col;

        // One extra bit so a sprite hanging off the right/bottom edge clips instead of wrapping.
        assign w_x_end  = {1'b0, r_act_x[i]} + (XY_W+1)'(SPR_W);
        assign w_y_end  = {1'b0, r_act_y[i]} + (XY_W+1)'(SPR_H);
        assign w_hit[i] = r_act_en[i]
                       && (xpos >= r_act_x[i]) && ({1'b0, xpos} < w_x_end)
                       && (ypos >= r_act_y[i]) && ({1'b0, ypos} < w_y_end);
        assign w_dx = xpos - r_act_x[i];
        assign w_dy = ypos - r_act_y[i];
`ifdef SPRITE_MIRROR_EN
        assign w_col = r_act_mir[i] ? (XY_W'(SPR_W - 1) - w_dx) : w_dx;
`else
        assign w_col = w_dx;
`endif
        assign w_addr[i] = ADDR_W'(w_dy) * ADDR_W'(SPR_W) + ADDR_W'(w_col);
    end

    logic                   r_s1_valid;
    logic [NUM_LAYERS-1:0]  r_s1_hit;
    logic [PIX_W-1:0]       r_s1_bg;
    logic [NUM_LAYERS*ADDR_W-1:0] r_addr;
    logic                   r_dly_valid [ROM_LAT];
    logic [NUM_LAYERS-1:0]  r_dly_hit   [ROM_LAT];
    logic [PIX_W-1:0]       r_dly_bg    [ROM_LAT];

    assign spr_addr = r_addr;

    // Stage 1 latches hit/address; the delay line lines hit/bg up with ROM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_hit   <= '0;
            r_s1_bg    <= '0;
            r_addr     <= '0;
            for (int k = 0; k < ROM_LAT; k++) begin
                r_dly_valid[k] <= 1'b0;
                r_dly_hit[k]   <= '0;
                r_dly_bg[k]    <= '0;
            end
        end else begin
            r_s1_valid <= pix_valid;
            r_s1_hit   <= w_hit;
            r_s1_bg    <= bg_rgb;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (w_hit[i]) begin
                    r_addr[i*ADDR_W +: ADDR_W] <= w_addr[i];
                end
            end
            r_dly_valid[0] <= r_s1_valid;
            r_dly_hit[0]   <= r_s1_hit;
            r_dly_bg[0]    <= r_s1_bg;
            for (int k = 1; k < ROM_LAT; k++) begin
                r_dly_valid[k] <= r_dly_valid[k-1];
                r_dly_hit[k]   <= r_dly_hit[k-1];
                r_dly_bg[k]    <= r_dly_bg[k-1];
            end
        end
    end

    logic [PIX_W-1:0] w_pix;

    // Walk from lowest priority upward so the lowest-index opaque layer wins.
    always_comb begin
        w_pix = r_dly_bg[ROM_LAT-1];
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (r_dly_hit[ROM_LAT-1][i] && (spr_rgb[i*PIX_W +: PIX_W] != KEY_RGB)) begin
                w_pix = spr_rgb[i*PIX_W +: PIX_W];
            end
        end
    end

    logic             r_out_valid;
    logic [PIX_W-1:0] r_rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_rgb       <= '0;
        end else begin
            r_out_valid <= r_dly_valid[ROM_LAT-1];
            r_rgb       <= r_dly_valid[ROM_LAT-1] ? w_pix : '0;
        end
    end

    assign out_valid = r_out_valid;
    assign R         = r_rgb[3*COLOR_W-1 -: COLOR_W];
    assign G         = r_rgb[2*COLOR_W-1 -: COLOR_W];
    assign B         = r_rgb[COLOR_W-1   -: COLOR_W];

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_compositor
// Purpose  : scoreboard bench for sprite_compositor (default build, ROM_LAT=1)
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_compositor;

    logic        clk;
    logic        rst_n;
    logic        pix_valid;
    logic [9:0]  xpos, ypos;
    logic [11:0] bg_rgb;
    logic        frame_start;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_layer;
    logic [9:0]  cfg_x, cfg_y;
    logic        cfg_en;
    logic [31:0] spr_addr;
    logic [47:0] spr_rgb;
    logic [3:0]  R, G, B;
    logic        out_valid;
    logic [11:0] tex [4];

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    typedef struct { int cyc; logic [11:0] rgb; } pix_e_t;
    typedef struct { int cyc; int sel; int idx; int val; } chk_e_t;
    pix_e_t pix_q [$];
    chk_e_t chk_q [$];
    pix_e_t m_pe;
    chk_e_t m_ce;

    sprite_compositor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .xpos       (xpos),
        .ypos       (ypos),
        .bg_rgb     (bg_rgb),
        .frame_start(frame_start),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_layer  (cfg_layer),
        .cfg_x      (cfg_x),
        .cfg_y      (cfg_y),
        .cfg_en     (cfg_en),
`ifdef SPRITE_MIRROR_EN
        .cfg_mirror (1'b0),
`endif
        .spr_addr   (spr_addr),
        .spr_rgb    (spr_rgb),
        .R          (R),
        .G          (G),
        .B          (B),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Texel ROM model: one cycle latency, one constant texel per layer
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) spr_rgb[i*12 +: 12] <= tex[i];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares outputs against the queued expectations
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (pix_q.size() == 0) begin
                    check("out_valid_unexpected", out_valid, 0);
                end else begin
                    m_pe = pix_q.pop_front();
                    check("pixel_latency", cyc, m_pe.cyc);
                    check("pixel_rgb", {R, G, B}, m_pe.rgb);
                end
            end else begin
                check("blank_rgb", {R, G, B}, 12'h000);
                if (pix_q.size() > 0 && pix_q[0].cyc <= cyc) begin
                    m_pe = pix_q.pop_front();
                    check("missing_out_valid", out_valid, 1);
                end
            end
            while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
                m_ce = chk_q.pop_front();
                if (m_ce.cyc != cyc) check("chk_late", cyc, m_ce.cyc);
                else if (m_ce.sel == 0) check("spr_addr", spr_addr[m_ce.idx*8 +: 8], m_ce.val);
                else check("cfg_ready", cfg_ready, m_ce.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        cfg_valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y,
                       input logic [11:0] bg, input logic [11:0] exp);
        tick();
        pix_valid = 1'b1;
        xpos      = x;
        ypos      = y;
        bg_rgb    = bg;
        pix_q.push_back('{cyc + 3, exp});
    endtask

    task automatic exp_addr(input int layer, input int val);
        chk_q.push_back('{cyc + 1, 0, layer, val});
    endtask

    task automatic exp_ready_pulse();
        chk_q.push_back('{cyc,     1, 0, 1});
        chk_q.push_back('{cyc + 1, 1, 0, 0});
        chk_q.push_back('{cyc + 2, 1, 0, 1});
    endtask

    task automatic cfg(input logic [1:0] l, input logic [9:0] x, input logic [9:0] y,
                       input logic en, input logic fs);
        tick();
        cfg_valid   = 1'b1;
        cfg_layer   = l;
        cfg_x       = x;
        cfg_y       = y;
        cfg_en      = en;
        frame_start = fs;
        if (fs) begin
            exp_ready_pulse();
            tick();
        end else begin
            chk_q.push_back('{cyc, 1, 0, 1});
        end
    endtask

    task automatic frame();
        tick();
        frame_start = 1'b1;
        exp_ready_pulse();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pix_valid = 1'b0; xpos = '0; ypos = '0; bg_rgb = '0;
        frame_start = 1'b0; cfg_valid = 1'b0; cfg_layer = '0; cfg_x = '0;
        cfg_y = '0; cfg_en = 1'b0;
        for (int i = 0; i < 4; i++) tex[i] = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_rgb", {R, G, B}, 12'h000);
        check("rst_spr_addr", spr_addr, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        rst_n = 1'b1;

        // All layers disabled: background passes through, bubble preserved
        pix(10, 5, 12'h123, 12'h123);
        pix(11, 5, 12'h123, 12'h123);
        tick();
        pix(12, 5, 12'h123, 12'h123);

        // Layer 0 at (100,50): not visible until committed
        tex[0] = 12'hABC;
        cfg(0, 100, 50, 1, 0);
        pix(100, 50, 12'h456, 12'h456);
        frame();
        pix(100, 50, 12'h456, 12'hABC); exp_addr(0, 0);
        pix(115, 65, 12'h456, 12'hABC); exp_addr(0, 255);
        pix(99, 50, 12'h456, 12'h456);  exp_addr(0, 255);
        pix(116, 50, 12'h456, 12'h456);

        // Overlap of layers 0 and 1 at (200,100)
        idle(3);
        tex[0] = 12'hF0F; tex[1] = 12'h0F0;
        cfg(0, 200, 100, 1, 0);
        cfg(1, 200, 100, 1, 0);
        frame();
        pix(200, 100, 12'h456, 12'h0F0);
        idle(3);
        tex[0] = 12'h00F;
        pix(205, 105, 12'h456, 12'h00F); exp_addr(0, 85); exp_addr(1, 85);
        idle(3);
        tex[0] = 12'hF0F; tex[1] = 12'hF0F;
        pix(210, 110, 12'h456, 12'h456);
        idle(3);
        tex[0] = 12'h00F; tex[1] = 12'h0F0; tex[2] = 12'h777;

        // Sprite at right edge clips, no wrap to column 0
        cfg(2, 1020, 0, 1, 0);
        frame();
        pix(1020, 0, 12'h456, 12'h777);
        pix(1023, 0, 12'h456, 12'h777); exp_addr(2, 3);
        pix(0, 0, 12'h456, 12'h456);    exp_addr(2, 3);
        pix(11, 0, 12'h456, 12'h456);

        // Mid-frame write deferred; write coincident with frame_start committed
        cfg(0, 300, 100, 1, 0);
        pix(200, 100, 12'h456, 12'h00F);
        pix(300, 100, 12'h456, 12'h456);
        cfg(0, 400, 100, 1, 1);
        pix(200, 100, 12'h456, 12'h0F0);
        pix(300, 100, 12'h456, 12'h456);
        pix(400, 100, 12'h456, 12'h00F);

        // Asynchronous reset while pixels are on the output
        pix(400, 100, 12'h456, 12'h00F);
        pix(401, 100, 12'h456, 12'h00F);
        pix(402, 100, 12'h456, 12'h00F);
        pix(403, 100, 12'h456, 12'h00F);
        #2;
        rst_n = 1'b0;
        pix_valid = 1'b0;
        pix_q.delete();
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_rgb", {R, G, B}, 12'h000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_rst_cfg_ready", cfg_ready, 1);
        pix(400, 100, 12'h456, 12'h456);
        pix(200, 100, 12'h456, 12'h456);
        cfg(0, 400, 100, 1, 0);
        pix(400, 100, 12'h456, 12'h456);
        frame();
        pix(400, 100, 12'h456, 12'h00F);
        pix(200, 100, 12'h456, 12'h456);

        idle(6);
        check("pix_queue_drained", pix_q.size(), 0);
        check("chk_queue_drained", chk_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
